// File: rtl/eq_super_recognition.sv
// Two-stage pattern recognizer: checks whether an input pattern covers a
// stored weight pattern and counts the weight bits it hits and misses.
module eq_super_recognition #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in,
    input  logic [WIDTH-1:0]           weight,
    output logic                       recognition,
    output logic                       exact,
    output logic                       superset,
    output logic [$clog2(WIDTH+1)-1:0] hit_count,
    output logic [$clog2(WIDTH+1)-1:0] miss_count,
    output logic                       out_valid
);

    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    logic             r_in_valid;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] r_weight;

    logic             r_out_valid;
    logic             r_recognition;
    logic             r_exact;
    logic             r_superset;
    logic [CW-1:0]    r_hit_count;
    logic [CW-1:0]    r_miss_count;

    logic             w_weight_nz;
    logic [CW-1:0]    w_hit_count;
    logic [CW-1:0]    w_miss_count;
    logic             w_recognition;
    logic             w_exact;
    logic             w_superset;

    // Stage 1: capture inputs every cycle, qualified or not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_valid <= 1'b0;
            r_in       <= {WIDTH{1'b0}};
            r_weight   <= {WIDTH{1'b0}};
        end else begin
            r_in_valid <= in_valid;
            r_in       <= in;
            r_weight   <= weight;
        end
    end

    // A zero weight forces every result to zero; counts are naturally zero then
    assign w_weight_nz   = |r_weight;
    assign w_hit_count   = popcount(r_in & r_weight);
    assign w_miss_count  = popcount(r_weight & ~r_in);
    assign w_recognition = w_weight_nz && (w_miss_count == {CW{1'b0}});
    assign w_exact       = w_weight_nz && (r_in == r_weight);
    assign w_superset    = w_recognition && !w_exact;

    // Stage 2: results update only for qualified patterns and hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_recognition <= 1'b0;
            r_exact       <= 1'b0;
            r_superset    <= 1'b0;
            r_hit_count   <= {CW{1'b0}};
            r_miss_count  <= {CW{1'b0}};
        end else begin
            r_out_valid <= r_in_valid;
            if (r_in_valid) begin
                r_recognition <= w_recognition;
                r_exact       <= w_exact;
                r_superset    <= w_superset;
                r_hit_count   <= w_hit_count;
                r_miss_count  <= w_miss_count;
            end else begin
                r_recognition <= r_recognition;
                r_exact       <= r_exact;
                r_superset    <= r_superset;
                r_hit_count   <= r_hit_count;
                r_miss_count  <= r_miss_count;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign recognition = r_recognition;
    assign exact       = r_exact;
    assign superset    = r_superset;
    assign hit_count   = r_hit_count;
    assign miss_count  = r_miss_count;

endmodule

// File: tb/tb_eq_super_recognition.sv
// Directed-vector bench for eq_super_recognition with hand-computed expectations.
module tb_eq_super_recognition;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_pat;
    logic [15:0] weight;
    logic        recognition;
    logic        exact;
    logic        superset;
    logic [4:0]  hit_count;
    logic [4:0]  miss_count;
    logic        out_valid;

    int checks;
    int failures;

    eq_super_recognition #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in          (in_pat),
        .weight      (weight),
        .recognition (recognition),
        .exact       (exact),
        .superset    (superset),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector table: in, weight, recognition, exact, superset, hit, miss
    localparam int NV = 10;
    logic [15:0] v_in   [NV] = '{16'hE444, 16'h4444, 16'hFC44, 16'hFFFF, 16'hFC44,
                                 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8001, 16'h0000};
    logic [15:0] v_w    [NV] = '{16'hE444, 16'hE444, 16'hE444, 16'hE444, 16'hFFFF,
                                 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
    logic        v_rec  [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        v_ex   [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        v_sup  [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0]  v_hit  [NV] = '{5'd6, 5'd4, 5'd6, 5'd6, 5'd8, 5'd16, 5'd0, 5'd0, 5'd1, 5'd0};
    logic [4:0]  v_miss [NV] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input int k);
        check_eq({tag, ".out_valid"},   32'(out_valid),   32'd1);
        check_eq({tag, ".recognition"}, 32'(recognition), 32'(v_rec[k]));
        check_eq({tag, ".exact"},       32'(exact),       32'(v_ex[k]));
        check_eq({tag, ".superset"},    32'(superset),    32'(v_sup[k]));
        check_eq({tag, ".hit"},         32'(hit_count),   32'(v_hit[k]));
        check_eq({tag, ".miss"},        32'(miss_count),  32'(v_miss[k]));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".out_valid"},   32'(out_valid),   32'd0);
        check_eq({tag, ".recognition"}, 32'(recognition), 32'd0);
        check_eq({tag, ".exact"},       32'(exact),       32'd0);
        check_eq({tag, ".superset"},    32'(superset),    32'd0);
        check_eq({tag, ".hit"},         32'(hit_count),   32'd0);
        check_eq({tag, ".miss"},        32'(miss_count),  32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pat   = 16'h0000;
        weight   = 16'h0000;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Isolated vectors: drive one cycle, result visible after two edges
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pat   = v_in[k];
            weight   = v_w[k];
            @(negedge clk);
            in_valid = 1'b0;
            in_pat   = 16'h0000;
            weight   = 16'hFFFF;
            check_eq($sformatf("vec%0d.early", k), 32'(out_valid), 32'd0);
            @(negedge clk);
            check_results($sformatf("vec%0d", k), k);
            @(negedge clk);
            check_eq($sformatf("vec%0d.drop", k), 32'(out_valid), 32'd0);
            check_eq($sformatf("vec%0d.hold_hit", k), 32'(hit_count), 32'(v_hit[k]));
            check_eq($sformatf("vec%0d.hold_rec", k), 32'(recognition), 32'(v_rec[k]));
        end

        // Back-to-back stream: each result lags its input by two cycles
        for (int k = 0; k < NV + 2; k++) begin
            @(negedge clk);
            if (k >= 2) check_results($sformatf("b2b%0d", k - 2), k - 2);
            if (k < NV) begin
                in_valid = 1'b1;
                in_pat   = v_in[k];
                weight   = v_w[k];
            end else begin
                in_valid = 1'b0;
                in_pat   = 16'h0000;
                weight   = 16'h0000;
            end
        end
        @(negedge clk);
        check_eq("b2b.tail", 32'(out_valid), 32'd0);

        // Reset mid-stream: outputs clear without a clock edge, in-flight data is lost
        in_valid = 1'b1;
        in_pat   = v_in[0];
        weight   = v_w[0];
        @(negedge clk);
        in_pat   = v_in[5];
        weight   = v_w[5];
        @(negedge clk);
        check_results("pre_rst", 0);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst%0d.out_valid", k), 32'(out_valid), 32'd0);
            check_eq($sformatf("post_rst%0d.hit", k), 32'(hit_count), 32'd0);
        end

        // First pattern after reset arrives with normal latency
        in_valid = 1'b1;
        in_pat   = v_in[4];
        weight   = v_w[4];
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("first.early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_results("first", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
